cci_mpf_csr_event_counters: RTL

Parametrised event-counter bank for the MPF CSR manager. Shims (VTP, WRO, future shims) drive per-cycle event increment lanes. The block accumulates each lane into a private counter, and an atomic snapshot/clear mechanism lets the MMIO read path return a mutually consistent set of values. It replaces the fixed set of hand-wired 1-bit VTP event counters with N configurable lanes, multi-count increments, and selectable wrap or saturate behaviour.

---
 rtl/cci_mpf_csr_event_counters.sv | 96 +++++++++
 1 files changed

// File: rtl/cci_mpf_csr_event_counters.sv
// Event-counter bank for the MPF CSR manager: N increment lanes feed private
// counters, and an atomic snapshot/clear lets MMIO reads see a coherent set.
module cci_mpf_csr_event_counters #(
  parameter int N_EVENTS      = 7,
  parameter int INC_WIDTH     = 2,
  parameter int COUNTER_WIDTH = 48,
  parameter bit SATURATE      = 1'b0,
  localparam int IDX_W        = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_EVENTS*INC_WIDTH-1:0] events,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          snapshot,
  input  logic                          rd_req,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic                          rd_rsp_valid,
  output logic [IDX_W-1:0]              rd_rsp_idx,
  output logic [63:0]                   rd_rsp_data,
  output logic [N_EVENTS-1:0]           ovf
);

  logic [N_EVENTS*INC_WIDTH-1:0] evt_q;
  logic                          en_q;
  logic [COUNTER_WIDTH-1:0]      cnt    [N_EVENTS];
  logic [COUNTER_WIDTH-1:0]      shadow [N_EVENTS];
  logic [COUNTER_WIDTH:0]        sum    [N_EVENTS];
  logic [63:0]                   rd_value;

  // One extra bit on every sum so the carry-out flags overflow directly.
  always_comb begin
    for (int i = 0; i < N_EVENTS; i++) begin
      sum[i] = {1'b0, cnt[i]} + (COUNTER_WIDTH+1)'(evt_q[i*INC_WIDTH +: INC_WIDTH]);
    end
  end

  // A read in the same cycle as a snapshot returns the value being captured.
  // Indices beyond the last lane match nothing and fall through to zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves rd_value unassigned (no latch).
    rd_value = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_value = snapshot ? 64'(cnt[i]) : 64'(shadow[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_q        <= '0;
      en_q         <= 1'b0;
      ovf          <= '0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_idx   <= '0;
      rd_rsp_data  <= '0;
      // NOTE: counters and shadows are flop arrays rather than a RAM, so they can
      // and must be reset element by element; reads after reset must return 0.
      for (int i = 0; i < N_EVENTS; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments, so shadow captures cnt as it was before
      // this cycle's clear or increment.
      evt_q <= events;
      en_q  <= enable;

      for (int i = 0; i < N_EVENTS; i++) begin
        if (snapshot) begin
          shadow[i] <= cnt[i];
        end

        if (clear) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (en_q) begin
          if (sum[i][COUNTER_WIDTH]) begin
            ovf[i] <= 1'b1;
            cnt[i] <= SATURATE ? '1 : sum[i][COUNTER_WIDTH-1:0];
          end else begin
            cnt[i] <= sum[i][COUNTER_WIDTH-1:0];
          end
        end
      end

      rd_rsp_valid <= rd_req;
      if (rd_req) begin
        rd_rsp_idx  <= rd_idx;
        rd_rsp_data <= rd_value;
      end
    end
  end

endmodule
